// File: rtl/register_pkg.sv
// Shared register-level types for the PHY datapath: lane rate selection and
// the MAC frame byte serializer state encoding.
package register_pkg;

  typedef enum logic [1:0] {
    RATE_GEN1 = 2'd0,
    RATE_GEN2 = 2'd1,
    RATE_GEN3 = 2'd2
  } active_data_rate_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } serializer_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; full/empty derive from an explicit level counter
// so the power-of-2 pointers can wrap freely.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push_ok, pop_ok;

  assign full_o    = (level_q == LVL_W'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/mac_frame_byte_serializer.sv
// Buffers wide MAC frames and emits them LSB-first as a byte stream under a
// valid/ready handshake, chaining frames back-to-back without bubbles.
module mac_frame_byte_serializer #(
  parameter int unsigned MAC_FRAME_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH      = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [MAC_FRAME_WIDTH-1:0]      mac_data_frame_i,
  input  logic                            mac_data_frame_valid_i,
  output logic                            mac_data_frame_ready_o,
  output logic [7:0]                      byte_o,
  output logic                            byte_valid_o,
  input  logic                            byte_ready_i,
  output logic                            byte_first_o,
  output logic                            byte_last_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_o
);

  import register_pkg::*;

  localparam int unsigned BYTES_PER_FRAME = MAC_FRAME_WIDTH / 8;
  localparam int unsigned IDX_W           = $clog2(BYTES_PER_FRAME);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BYTES_PER_FRAME - 1);

  serializer_state_e          state_q, state_d;
  logic [MAC_FRAME_WIDTH-1:0] shreg_q;
  logic [IDX_W-1:0]           idx_q;
  logic [MAC_FRAME_WIDTH-1:0] fifo_rd_data;
  logic                       fifo_full, fifo_empty;
  logic                       push, pop, byte_xfer;
  logic [7:0]                 frame_bytes [BYTES_PER_FRAME];

  // Ready comes from the registered level only, never from byte_ready_i.
  assign mac_data_frame_ready_o = !fifo_full;
  assign push                   = mac_data_frame_valid_i && mac_data_frame_ready_o;
  assign byte_xfer              = (state_q == SHIFT) && byte_ready_i;

  sync_fifo #(
    .WIDTH (MAC_FRAME_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (push),
    .wr_data_i (mac_data_frame_i),
    .pop_i     (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (byte_xfer && (idx_q == LAST_IDX)) begin
          if (!fifo_empty) pop     = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop always coincides with idx being 0 next, so the shift register load
  // and the index wrap can be handled independently.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      if (pop) shreg_q <= fifo_rd_data;
      if (byte_xfer) idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < BYTES_PER_FRAME; i++) begin
      frame_bytes[i] = shreg_q[8*i +: 8];
    end
  end

  always_comb begin
    byte_valid_o = (state_q == SHIFT);
    byte_o       = byte_valid_o ? frame_bytes[idx_q] : '0;
    byte_first_o = byte_valid_o && (idx_q == '0);
    byte_last_o  = byte_valid_o && (idx_q == LAST_IDX);
  end

endmodule

// File: tb/tb_mac_frame_byte_serializer.sv
// Self-checking bench for mac_frame_byte_serializer: directed vector table,
// full-FIFO/reset/wide-frame sequences and a randomized stall run.
module tb_mac_frame_byte_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mframe;
  logic        mvalid, mready;
  logic [7:0]  bdata;
  logic        bvalid, bready, bfirst, blast;
  logic [1:0]  level;

  logic [63:0] w_mframe;
  logic        w_mvalid, w_mready;
  logic [7:0]  w_bdata;
  logic        w_bvalid, w_bready, w_bfirst, w_blast;
  logic [1:0]  w_level;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mac_frame_byte_serializer #(.MAC_FRAME_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .mac_data_frame_i(mframe), .mac_data_frame_valid_i(mvalid),
    .mac_data_frame_ready_o(mready),
    .byte_o(bdata), .byte_valid_o(bvalid), .byte_ready_i(bready),
    .byte_first_o(bfirst), .byte_last_o(blast), .fifo_level_o(level)
  );

  mac_frame_byte_serializer #(.MAC_FRAME_WIDTH(64), .FIFO_DEPTH(2)) dut_w (
    .clk_i(clk), .rst_i(rst),
    .mac_data_frame_i(w_mframe), .mac_data_frame_valid_i(w_mvalid),
    .mac_data_frame_ready_o(w_mready),
    .byte_o(w_bdata), .byte_valid_o(w_bvalid), .byte_ready_i(w_bready),
    .byte_first_o(w_bfirst), .byte_last_o(w_blast), .fifo_level_o(w_level)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        push;
    logic [31:0] frame;
    logic        brdy;
    logic        ev;
    logic [7:0]  eb;
    logic        ef;
    logic        el;
    logic [1:0]  elev;
    logic        erdy;
  } vec_t;

  function automatic vec_t mkv(logic p, logic [31:0] f, logic r, logic ev, logic [7:0] eb,
                               logic ef, logic el, logic [1:0] elev, logic erdy);
    vec_t v;
    v.push = p; v.frame = f; v.brdy = r; v.ev = ev; v.eb = eb;
    v.ef = ef; v.el = el; v.elev = elev; v.erdy = erdy;
    return v;
  endfunction

  vec_t vecs [17];
  logic [7:0] exp_q [$];

  initial begin
    int pushed, consumed, cycles;
    logic prev_stall;
    logic [7:0] prev_byte;

    rst = 1'b1; mvalid = 1'b0; mframe = '0; bready = 1'b0;
    w_mvalid = 1'b0; w_mframe = '0; w_bready = 1'b0;

    // Expected outputs are those observed at the negedge before applying the inputs.
    vecs[0]  = mkv(1, 32'hDDCC_BBAA, 1, 0, 8'h00, 0, 0, 0, 1);
    vecs[1]  = mkv(0, 32'h0,         1, 0, 8'h00, 0, 0, 1, 1);
    vecs[2]  = mkv(0, 32'h0,         1, 1, 8'hAA, 1, 0, 0, 1);
    vecs[3]  = mkv(0, 32'h0,         1, 1, 8'hBB, 0, 0, 0, 1);
    vecs[4]  = mkv(0, 32'h0,         1, 1, 8'hCC, 0, 0, 0, 1);
    vecs[5]  = mkv(0, 32'h0,         1, 1, 8'hDD, 0, 1, 0, 1);
    vecs[6]  = mkv(1, 32'h0302_0100, 1, 0, 8'h00, 0, 0, 0, 1);
    vecs[7]  = mkv(1, 32'h0706_0504, 1, 0, 8'h00, 0, 0, 1, 1);
    vecs[8]  = mkv(0, 32'h0,         1, 1, 8'h00, 1, 0, 1, 1);
    vecs[9]  = mkv(0, 32'h0,         1, 1, 8'h01, 0, 0, 1, 1);
    vecs[10] = mkv(0, 32'h0,         1, 1, 8'h02, 0, 0, 1, 1);
    vecs[11] = mkv(0, 32'h0,         1, 1, 8'h03, 0, 1, 1, 1);
    vecs[12] = mkv(0, 32'h0,         1, 1, 8'h04, 1, 0, 0, 1);
    vecs[13] = mkv(0, 32'h0,         1, 1, 8'h05, 0, 0, 0, 1);
    vecs[14] = mkv(0, 32'h0,         1, 1, 8'h06, 0, 0, 0, 1);
    vecs[15] = mkv(0, 32'h0,         1, 1, 8'h07, 0, 1, 0, 1);
    vecs[16] = mkv(0, 32'h0,         1, 0, 8'h00, 0, 0, 0, 1);

    // Reset state
    @(negedge clk);
    check("rst_ready", mready, 1);
    check("rst_valid", bvalid, 0);
    check("rst_byte", bdata, 0);
    check("rst_first", bfirst, 0);
    check("rst_last", blast, 0);
    check("rst_level", level, 0);
    check("rst_w_ready", w_mready, 1);
    check("rst_w_valid", w_bvalid, 0);
    rst = 1'b0;

    // Single frame and back-to-back frames
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), bvalid, vecs[i].ev);
      check($sformatf("vec%0d_byte", i),  bdata,  vecs[i].eb);
      check($sformatf("vec%0d_first", i), bfirst, vecs[i].ef);
      check($sformatf("vec%0d_last", i),  blast,  vecs[i].el);
      check($sformatf("vec%0d_level", i), level,  vecs[i].elev);
      check($sformatf("vec%0d_ready", i), mready, vecs[i].erdy);
      mvalid = vecs[i].push; mframe = vecs[i].frame; bready = vecs[i].brdy;
    end

    // Full FIFO with the consumer stalled
    @(negedge clk);
    check("full_lvl0", level, 0);
    bready = 1'b0; mvalid = 1'b1; mframe = 32'h1312_1110;
    @(negedge clk);
    check("full_lvl1a", level, 1);
    mframe = 32'h1716_1514;
    @(negedge clk);
    check("full_lvl1b", level, 1);
    check("full_hold_valid", bvalid, 1);
    mframe = 32'h1B1A_1918;
    @(negedge clk);
    check("full_lvl2", level, 2);
    check("full_ready_low", mready, 0);
    mvalid = 1'b0;
    @(negedge clk);
    check("full_stall_byte", bdata, 8'h10);
    check("full_stall_first", bfirst, 1);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("full_b%0d", k), bdata, 8'(8'h10 + k));
      check($sformatf("full_v%0d", k), bvalid, 1);
      check($sformatf("full_rdy%0d", k), mready, (k >= 4) ? 1'b1 : 1'b0);
      check($sformatf("full_lv%0d", k), level, (k < 4) ? 2'd2 : (k < 8) ? 2'd1 : 2'd0);
      bready = 1'b1;
    end
    @(negedge clk);
    check("full_done_valid", bvalid, 0);

    // Reset in the middle of a frame with another frame queued
    mvalid = 1'b1; mframe = 32'hDDCC_BBAA; bready = 1'b1;
    @(negedge clk);
    mframe = 32'h4433_2211;
    @(negedge clk);
    mvalid = 1'b0;
    check("mid_aa", bdata, 8'hAA);
    @(negedge clk);
    check("mid_bb", bdata, 8'hBB);
    check("mid_queued", level, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", bvalid, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_ready", mready, 1);
    check("mid_rst_byte", bdata, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("mid_stale%0d", k), bvalid, 0);
    end
    check("mid_post_level", level, 0);

    // Randomized stall run against a byte-queue model
    pushed = 0; consumed = 0; cycles = 0; prev_stall = 1'b0; prev_byte = '0;
    exp_q.delete();
    while (!(pushed == 100 && exp_q.size() == 0) && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      if (prev_stall) begin
        check("rnd_hold_valid", bvalid, 1);
        check("rnd_hold_byte", bdata, prev_byte);
      end
      if (bvalid) begin
        if (exp_q.size() == 0) check("rnd_spurious_valid", bvalid, 0);
        else begin
          check("rnd_byte", bdata, exp_q[0]);
          check("rnd_first", bfirst, (consumed % 4) == 0);
          check("rnd_last", blast, (consumed % 4) == 3);
        end
      end else begin
        check("rnd_idle_first", bfirst, 0);
        check("rnd_idle_last", blast, 0);
      end
      mvalid = (pushed < 100) && ($urandom_range(0, 2) != 0);
      mframe = $urandom;
      bready = $urandom_range(0, 1) == 1;
      if (mvalid && mready) begin
        for (int b = 0; b < 4; b++) exp_q.push_back(mframe[8*b +: 8]);
        pushed++;
      end
      if (bvalid && bready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        consumed++;
      end
      prev_stall = bvalid && !bready;
      prev_byte  = bdata;
    end
    check("rnd_completed", (cycles < 5000) ? 1'b1 : 1'b0, 1);
    check("rnd_byte_count", consumed, 400);
    mvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rnd_end_valid", bvalid, 0);

    // Wide frame
    w_mvalid = 1'b1; w_mframe = 64'h0706_0504_0302_0100; w_bready = 1'b1;
    @(negedge clk);
    w_mvalid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("wide_b%0d", k), w_bdata, 8'(k));
      check($sformatf("wide_v%0d", k), w_bvalid, 1);
      check($sformatf("wide_f%0d", k), w_bfirst, k == 0);
      check($sformatf("wide_l%0d", k), w_blast, k == 7);
    end
    @(negedge clk);
    check("wide_done_valid", w_bvalid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
